// File: rtl/phys_mem_pkg.sv
// Shared constants for the physical memory controller: address map, write FSM states
// and UART status-bit positions.
package phys_mem_pkg;

   localparam logic [31:0] SRAM_LIMIT     = 32'h0040_0000;
   localparam logic [31:0] UART_DATA_ADDR = 32'h1FD0_03F8;
   localparam logic [31:0] UART_STAT_ADDR = 32'h1FD0_03FC;

   localparam int STAT_TX_RDY   = 0;
   localparam int STAT_RX_AVAIL = 1;
   localparam int STAT_RX_OVR   = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_SETUP = 2'd1,
      ST_WR_PULSE = 2'd2,
      ST_WR_HOLD  = 2'd3
   } wr_state_e;

   function automatic logic is_sram(input logic [31:0] a);
      return a < SRAM_LIMIT;
   endfunction

endpackage

// File: rtl/phys_mem_ctrl_uart_rx_fifo.sv
// UART receive buffer with sticky overrun flag. PHYS_MEM_RX_FIFO_EN selects a DEPTH-entry
// circular FIFO; otherwise a single holding register is used.
module phys_mem_ctrl_uart_rx_fifo
   import phys_mem_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [7:0]             data_i,
   input  logic                   pop_i,
   input  logic                   ovr_clr_i,
   output logic [7:0]             head_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   ovr_o
);

   logic do_push;
   logic do_pop;
   logic ovr_q;
   logic ovr_d;

`ifdef PHYS_MEM_RX_FIFO_EN
   localparam int PTR_W = $clog2(DEPTH);

   logic [7:0]       mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [PTR_W:0]   count_d;
   logic             full;
   logic             empty;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);

   assign do_pop  = pop_i && !empty;
   // A pop in the same cycle frees the slot, so a full buffer can still accept the byte.
   assign do_push = push_i && (!full || do_pop);

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + (PTR_W+1)'(1);
      end else if (do_pop && !do_push) begin
         count_d = count_q - (PTR_W+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         count_q <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;
`else
   logic [7:0] hold_q;
   logic       valid_q;

   assign do_pop  = pop_i && valid_q;
   assign do_push = push_i && (!valid_q || do_pop);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         if (do_push) begin
            hold_q <= data_i;
         end
         valid_q <= do_push || (valid_q && !do_pop);
      end
   end

   assign head_o  = hold_q;
   assign count_o = {{$clog2(DEPTH){1'b0}}, valid_q};
`endif

   // A dropped byte in the same cycle as a clear wins, so the event is never lost.
   always_comb begin
      ovr_d = ovr_q;
      if (ovr_clr_i) begin
         ovr_d = 1'b0;
      end
      if (push_i && !do_push) begin
         ovr_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_q <= 1'b0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign ovr_o = ovr_q;

endmodule

// File: rtl/phys_mem_ctrl.sv
// Physical memory controller: decodes MMU accesses onto async SRAM or UART registers.
// Define PHYS_MEM_RX_FIFO_EN for a multi-entry RX FIFO instead of a single holding register.
module phys_mem_ctrl
   import phys_mem_pkg::*;
#(
   parameter int WE_CYCLES     = 2,
   parameter int RX_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] addr_i,
   input  logic [31:0] data_in_i,
   input  logic        is_write_i,
   input  logic        is_data_read_i,
   output logic [31:0] data_out_o,
   output logic        busy_o,
   output logic [19:0] ram_addr_o,
   output logic [31:0] ram_data_o,
   input  logic [31:0] ram_data_i,
   output logic        ram_data_oe_o,
   output logic        ram_ce_n_o,
   output logic        ram_oe_n_o,
   output logic        ram_we_n_o,
   output logic [7:0]  uart_tx_data_o,
   output logic        uart_tx_start_o,
   input  logic        uart_tx_busy_i,
   input  logic [7:0]  uart_rx_data_i,
   input  logic        uart_rx_valid_i
);

   localparam int CNT_W    = $clog2(RX_FIFO_DEPTH) + 1;
   localparam int WE_CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
   localparam logic [WE_CNT_W-1:0] WE_LAST = WE_CNT_W'(WE_CYCLES - 1);

   wr_state_e           state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [WE_CNT_W-1:0] we_cnt_q, we_cnt_d;

   logic             busy_int;
   logic             wr_sram;
   logic             wr_uart;
   logic             rx_pop;
   logic             ovr_clr;
   logic             rx_avail;
   logic             rx_ovr;
   logic [7:0]       rx_head;
   logic [CNT_W-1:0] rx_count;
   logic [31:0]      status_word;

   assign busy_int = (state_q != ST_IDLE) || is_write_i;
   assign wr_sram  = is_sram(addr_q);
   assign wr_uart  = (addr_q == UART_DATA_ADDR);
   assign rx_avail = (rx_count != '0);
   assign rx_pop   = is_data_read_i && !busy_int && (addr_i == UART_DATA_ADDR) && rx_avail;
   assign ovr_clr  = is_data_read_i && !busy_int && (addr_i == UART_STAT_ADDR);

   phys_mem_ctrl_uart_rx_fifo #(
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (uart_rx_valid_i),
      .data_i    (uart_rx_data_i),
      .pop_i     (rx_pop),
      .ovr_clr_i (ovr_clr),
      .head_o    (rx_head),
      .count_o   (rx_count),
      .ovr_o     (rx_ovr)
   );

   always_comb begin
      status_word                = '0;
      status_word[STAT_TX_RDY]   = !uart_tx_busy_i;
      status_word[STAT_RX_AVAIL] = rx_avail;
      status_word[STAT_RX_OVR]   = rx_ovr;
   end

   always_comb begin
      data_out_o = '0;
      if (is_sram(addr_i)) begin
         data_out_o = ram_data_i;
      end else if (addr_i == UART_DATA_ADDR) begin
         data_out_o = {24'b0, (rx_avail ? rx_head : 8'h00)};
      end else if (addr_i == UART_STAT_ADDR) begin
         data_out_o = status_word;
      end
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      we_cnt_d = we_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (is_write_i) begin
               addr_d  = addr_i;
               wdata_d = data_in_i;
               state_d = ST_WR_SETUP;
            end
         end
         ST_WR_SETUP: begin
            we_cnt_d = '0;
            state_d  = ST_WR_PULSE;
         end
         ST_WR_PULSE: begin
            if (we_cnt_q == WE_LAST) begin
               state_d = ST_WR_HOLD;
            end else begin
               we_cnt_d = we_cnt_q + WE_CNT_W'(1);
            end
         end
         ST_WR_HOLD: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Strobes are decoded from the state so a reset pulls them inactive without a clock.
   always_comb begin
      ram_ce_n_o      = 1'b1;
      ram_oe_n_o      = 1'b1;
      ram_we_n_o      = 1'b1;
      ram_data_oe_o   = 1'b0;
      uart_tx_start_o = 1'b0;
      ram_addr_o      = addr_i[21:2];
      if (state_q == ST_IDLE) begin
         if (!is_write_i && rst_n) begin
            ram_ce_n_o = 1'b0;
            ram_oe_n_o = 1'b0;
         end
      end else begin
         ram_addr_o    = addr_q[21:2];
         ram_data_oe_o = 1'b1;
         ram_ce_n_o    = !wr_sram;
         if ((state_q == ST_WR_SETUP) && wr_uart && !uart_tx_busy_i) begin
            uart_tx_start_o = 1'b1;
         end
         if ((state_q == ST_WR_PULSE) && wr_sram) begin
            ram_we_n_o = 1'b0;
         end
      end
   end

   assign busy_o         = rst_n && busy_int;
   assign ram_data_o     = wdata_q;
   assign uart_tx_data_o = wdata_q[7:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         we_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         we_cnt_q <= we_cnt_d;
      end
   end

endmodule

// File: tb/tb_phys_mem_ctrl.sv
// Randomized bench for phys_mem_ctrl against a queue-based behavioural model.
module tb_phys_mem_ctrl;

   localparam int WE = 2;
`ifdef PHYS_MEM_RX_FIFO_EN
   localparam int MDEPTH = 8;
`else
   localparam int MDEPTH = 1;
`endif
   localparam logic [31:0] A_DATA  = 32'h1FD0_03F8;
   localparam logic [31:0] A_STAT  = 32'h1FD0_03FC;
   localparam logic [31:0] A_OTHER = 32'h1FD0_0400;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] addr = 32'h0;
   logic [31:0] data_in = 32'h0;
   logic [31:0] ram_rd = 32'h0;
   logic        is_write = 1'b0;
   logic        is_data_read = 1'b0;
   logic        tx_busy = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h0;

   logic [31:0] data_out;
   logic        busy;
   logic [19:0] ram_addr;
   logic [31:0] ram_data_o;
   logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
   logic [7:0]  tx_data;
   logic        tx_start;

   phys_mem_ctrl #(.WE_CYCLES(WE), .RX_FIFO_DEPTH(8)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .addr_i          (addr),
      .data_in_i       (data_in),
      .is_write_i      (is_write),
      .is_data_read_i  (is_data_read),
      .data_out_o      (data_out),
      .busy_o          (busy),
      .ram_addr_o      (ram_addr),
      .ram_data_o      (ram_data_o),
      .ram_data_i      (ram_rd),
      .ram_data_oe_o   (ram_data_oe),
      .ram_ce_n_o      (ram_ce_n),
      .ram_oe_n_o      (ram_oe_n),
      .ram_we_n_o      (ram_we_n),
      .uart_tx_data_o  (tx_data),
      .uart_tx_start_o (tx_start),
      .uart_tx_busy_i  (tx_busy),
      .uart_rx_data_i  (rx_data),
      .uart_rx_valid_i (rx_valid)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
   endtask

   // Model: RX bytes in a bounded queue, write progress as a cycle index since the request.
   logic [7:0]  rxq[$];
   logic        m_ovr = 1'b0;
   int          ph = 0;
   logic [31:0] w_addr = 32'h0;
   logic [31:0] w_data = 32'h0;

   function automatic logic sram_a(input logic [31:0] a);
      return a < 32'h0040_0000;
   endfunction

   function automatic logic [31:0] exp_read();
      if (sram_a(addr)) return ram_rd;
      if (addr == A_DATA) return (rxq.size() != 0) ? {24'b0, rxq[0]} : 32'h0;
      if (addr == A_STAT) return {29'b0, m_ovr, (rxq.size() != 0), !tx_busy};
      return 32'h0;
   endfunction

   task automatic sample();
      logic e_busy, in_pulse, e_start;
      #2;
      e_busy   = (ph != 0) || is_write;
      in_pulse = (ph >= 2) && (ph <= WE + 1);
      e_start  = (ph == 1) && (w_addr == A_DATA) && !tx_busy;
      check("busy", 32'(busy), 32'(e_busy));
      check("data_out", data_out, exp_read());
      check("we_n", 32'(ram_we_n), 32'(!(in_pulse && sram_a(w_addr))));
      check("data_oe", 32'(ram_data_oe), 32'(ph != 0));
      check("tx_start", 32'(tx_start), 32'(e_start));
      if (e_start) check("tx_data", 32'(tx_data), 32'(w_data[7:0]));
      if (ph == 0 && !is_write) begin
         check("ce_n", 32'(ram_ce_n), 32'h0);
         check("oe_n", 32'(ram_oe_n), 32'h0);
         check("ram_addr", 32'(ram_addr), 32'(addr[21:2]));
      end else if (ph != 0) begin
         check("wr_oe_n", 32'(ram_oe_n), 32'h1);
         check("wr_data", ram_data_o, w_data);
         if (sram_a(w_addr)) check("wr_addr", 32'(ram_addr), 32'(w_addr[21:2]));
      end
   endtask

   task automatic advance();
      logic bz;
      bz = (ph != 0) || is_write;
      @(posedge clk);
      if (!bz && is_data_read && addr == A_DATA && rxq.size() != 0) void'(rxq.pop_front());
      if (!bz && is_data_read && addr == A_STAT) m_ovr = 1'b0;
      if (rx_valid) begin
         if (rxq.size() < MDEPTH) rxq.push_back(rx_data);
         else m_ovr = 1'b1;
      end
      if (ph == 0) begin
         if (is_write) begin
            ph = 1;
            w_addr = addr;
            w_data = data_in;
         end
      end else begin
         ph = (ph == WE + 2) ? 0 : ph + 1;
      end
      @(negedge clk);
   endtask

   task automatic step();
      sample();
      advance();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           output int pulses, output logic [7:0] txd, output int nbusy);
      addr = a; data_in = d; is_write = 1'b1; is_data_read = 1'b0;
      pulses = 0; nbusy = 0; txd = 8'h0;
      for (int i = 0; i < WE + 4; i++) begin
         sample();
         if (tx_start) begin pulses++; txd = tx_data; end
         nbusy += int'(busy);
         advance();
         is_write = 1'b0;
         addr = A_OTHER;
      end
   endtask

   initial begin
      int nb, nw, pulses;
      logic [7:0] txd;

      addr = A_STAT;
      repeat (2) @(negedge clk);
      #2;
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_ce_n", 32'(ram_ce_n), 32'h1);
      check("rst_oe_n", 32'(ram_oe_n), 32'h1);
      check("rst_we_n", 32'(ram_we_n), 32'h1);
      check("rst_data_oe", 32'(ram_data_oe), 32'h0);
      check("rst_tx_start", 32'(tx_start), 32'h0);
      check("rst_status", data_out, 32'h1);
      @(negedge clk);
      rst_n = 1'b1;

      // SRAM read, zero latency
      addr = 32'h0000_0010; ram_rd = 32'hDEADBEEF; is_data_read = 1'b1;
      sample();
      check("t1_data", data_out, 32'hDEADBEEF);
      check("t1_ram_addr", 32'(ram_addr), 32'h4);
      check("t1_busy", 32'(busy), 32'h0);
      advance();

      // SRAM write timing
      is_data_read = 1'b0; addr = 32'h0000_0020; data_in = 32'h12345678; is_write = 1'b1;
      nb = 0; nw = 0;
      for (int i = 0; i < 8; i++) begin
         sample();
         nb += int'(busy);
         if (!ram_we_n) begin
            nw++;
            check("t2_we_addr", 32'(ram_addr), 32'h8);
            check("t2_we_data", ram_data_o, 32'h12345678);
         end
         advance();
         is_write = 1'b0;
         addr = 32'h0000_0100;
      end
      check("t2_busy_cycles", nb, WE + 3);
      check("t2_we_cycles", nw, WE);

      // UART transmit with transmitter idle and busy
      tx_busy = 1'b0;
      do_write(A_DATA, 32'h0000_0041, pulses, txd, nb);
      check("t3_pulses", pulses, 1);
      check("t3_txdata", 32'(txd), 32'h41);
      tx_busy = 1'b1;
      do_write(A_DATA, 32'h0000_0042, pulses, txd, nb);
      check("t3_busy_pulses", pulses, 0);
      check("t3_busy_cycles", nb, WE + 3);
      do_write(32'h8000_0000, 32'h5555_AAAA, pulses, txd, nb);
      check("t3_unmapped_cycles", nb, WE + 3);
      tx_busy = 1'b0;

      // RX overflow, fetches never pop, drain in order
      addr = A_OTHER;
      for (int i = 1; i <= 9; i++) begin
         rx_valid = 1'b1; rx_data = 8'(i);
         step();
      end
      rx_valid = 1'b0;
      addr = A_STAT; is_data_read = 1'b0;
      sample(); check("t4_status", data_out, 32'h7); advance();
      addr = A_DATA;
      repeat (3) step();
      is_data_read = 1'b1;
      for (int i = 1; i <= MDEPTH; i++) begin
         sample(); check("t4_pop", data_out, 32'(i)); advance();
      end
      sample(); check("t4_empty", data_out, 32'h0); advance();
      addr = A_STAT; is_data_read = 1'b0;
      sample(); check("t4_avail_bit", 32'(data_out[1]), 32'h0); advance();

      // Push and pop together while full; overrun clear by status data read
      is_data_read = 1'b1; addr = A_STAT; step();
      is_data_read = 1'b0; addr = A_OTHER;
      for (int i = 0; i < MDEPTH; i++) begin
         rx_valid = 1'b1; rx_data = 8'(8'h80 + i); step();
      end
      addr = A_DATA; is_data_read = 1'b1; rx_data = 8'hC0; rx_valid = 1'b1;
      step();
      rx_valid = 1'b0; addr = A_STAT; is_data_read = 1'b0;
      sample(); check("t5_status", data_out, 32'h3); advance();
      addr = A_DATA; is_data_read = 1'b1;
      for (int i = 1; i < MDEPTH; i++) begin
         sample(); check("t5_drain", data_out, 32'(8'h80 + i)); advance();
      end
      sample(); check("t5_last", data_out, 32'hC0); advance();
      addr = A_OTHER; is_data_read = 1'b0;
      for (int i = 0; i <= MDEPTH; i++) begin
         rx_valid = 1'b1; rx_data = 8'(i); step();
      end
      rx_valid = 1'b0; addr = A_STAT;
      sample(); check("t5_ovr_set", data_out, 32'h7); advance();
      is_data_read = 1'b1; step();
      is_data_read = 1'b0;
      sample(); check("t5_ovr_clr", data_out, 32'h3); advance();
      addr = A_DATA; is_data_read = 1'b1;
      repeat (MDEPTH) step();

      // Reset during the write pulse
      addr = 32'h0000_0040; data_in = 32'hCAFEF00D; is_write = 1'b1; is_data_read = 1'b0;
      step();
      is_write = 1'b0;
      step();
      #1 check("t6_we_low", 32'(ram_we_n), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("t6_we_n", 32'(ram_we_n), 32'h1);
      check("t6_busy", 32'(busy), 32'h0);
      check("t6_data_oe", 32'(ram_data_oe), 32'h0);
      rxq.delete(); m_ovr = 1'b0; ph = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      addr = 32'h0000_0044; ram_rd = 32'h0BADF00D; is_data_read = 1'b1;
      sample();
      check("t6_read", data_out, 32'h0BADF00D);
      check("t6_busy_after", 32'(busy), 32'h0);
      advance();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         is_write = (ph == 0) && ($urandom_range(0, 5) == 0);
         case ($urandom_range(0, 4))
            0, 1: addr = {10'b0, 20'($urandom), 2'b00};
            2: addr = A_DATA;
            3: addr = A_STAT;
            default: addr = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
         endcase
         data_in = $urandom;
         is_data_read = 1'($urandom_range(0, 1));
         tx_busy = ($urandom_range(0, 3) == 0);
         rx_valid = ($urandom_range(0, 2) == 0);
         rx_data = 8'($urandom);
         ram_rd = $urandom;
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
